// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared 7-segment definitions for the display digit decoders and the scan top.
//   SEG_OFF          : all segments dark, active-low form (gfedcba)
//   SEG_HEX_0..F     : glyph patterns for 0-9, A, b, C, d, E, F, active-low form
//   hex_to_seg()     : nibble -> active-low glyph pattern
// Bit order of every pattern: [0]=a [1]=b [2]=c [3]=d [4]=e [5]=f [6]=g.
// -----------------------------------------------------------------------------
package seg7_pkg;

   localparam logic [6:0] SEG_OFF   = 7'h7F;

   localparam logic [6:0] SEG_HEX_0 = 7'h40;
   localparam logic [6:0] SEG_HEX_1 = 7'h79;
   localparam logic [6:0] SEG_HEX_2 = 7'h24;
   localparam logic [6:0] SEG_HEX_3 = 7'h30;
   localparam logic [6:0] SEG_HEX_4 = 7'h19;
   localparam logic [6:0] SEG_HEX_5 = 7'h12;
   localparam logic [6:0] SEG_HEX_6 = 7'h02;
   localparam logic [6:0] SEG_HEX_7 = 7'h78;
   localparam logic [6:0] SEG_HEX_8 = 7'h00;
   localparam logic [6:0] SEG_HEX_9 = 7'h10;
   localparam logic [6:0] SEG_HEX_A = 7'h08;
   localparam logic [6:0] SEG_HEX_B = 7'h03;
   localparam logic [6:0] SEG_HEX_C = 7'h46;
   localparam logic [6:0] SEG_HEX_D = 7'h21;
   localparam logic [6:0] SEG_HEX_E = 7'h06;
   localparam logic [6:0] SEG_HEX_F = 7'h0E;

   // All 16 codes are covered. The up-front SEG_OFF assignment only matters
   // for an unknown nibble, which then decodes to a dark digit instead of X.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
      logic [6:0] pattern;
      pattern = SEG_OFF;
      case (value)
         4'h0: pattern = SEG_HEX_0;
         4'h1: pattern = SEG_HEX_1;
         4'h2: pattern = SEG_HEX_2;
         4'h3: pattern = SEG_HEX_3;
         4'h4: pattern = SEG_HEX_4;
         4'h5: pattern = SEG_HEX_5;
         4'h6: pattern = SEG_HEX_6;
         4'h7: pattern = SEG_HEX_7;
         4'h8: pattern = SEG_HEX_8;
         4'h9: pattern = SEG_HEX_9;
         4'hA: pattern = SEG_HEX_A;
         4'hB: pattern = SEG_HEX_B;
         4'hC: pattern = SEG_HEX_C;
         4'hD: pattern = SEG_HEX_D;
         4'hE: pattern = SEG_HEX_E;
         4'hF: pattern = SEG_HEX_F;
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/disp_num_hex_decoder_if.sv
// -----------------------------------------------------------------------------
// disp_num_hex_decoder_if
// Board-side bundle of the four-digit hex display.
//   sw  [15:0] : switch word, nibble i is shown on digit i
//   an  [3:0]  : digit anodes, one-hot-low (0 = digit enabled)
//   seg [6:0]  : shared segment bus, gfedcba
// master drives the switches and observes the display; slave is the display.
// -----------------------------------------------------------------------------
interface disp_num_hex_decoder_if;
   logic [15:0] sw;
   logic [3:0]  an;
   logic [6:0]  seg;

   modport master (output sw, input an, input seg);
   modport slave  (input sw, output an, output seg);
endinterface

// File: rtl/disp_num.sv
// -----------------------------------------------------------------------------
// disp_num
// Registered 4-bit hex to 7-segment decoder, one display digit.
//   num [3:0] : hex value to show
//   clk       : rising-edge clock
//   seg [6:0] : registered segment drive, gfedcba
//   rst       : synchronous active-high reset, forces all segments dark
// Port order is num, clk, seg, rst so that older positional 3-port instances
// still connect; rst last keeps such instances legal.
// SEG_ACTIVE_LOW = 1 drives a lit segment as 0; 0 inverts every output bit.
// -----------------------------------------------------------------------------
module disp_num #(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] num,
   input  logic       clk,
   output logic [6:0] seg,
   input  logic       rst
);
   import seg7_pkg::*;

   // Package patterns are active-low; this mask flips them for active-high parts.
   localparam logic [6:0] POL_MASK = {7{!SEG_ACTIVE_LOW}};
   localparam logic [6:0] OFF_PAT  = SEG_OFF ^ POL_MASK;

   // The initial value makes the digit power up dark even if no reset is issued.
   logic [6:0] seg_reg = OFF_PAT;
   logic [6:0] seg_next;

   always_comb begin
      seg_next = hex_to_seg(num) ^ POL_MASK;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_reg <= OFF_PAT;
      end else begin
         seg_reg <= seg_next;
      end
   end

   assign seg = seg_reg;

`ifndef SYNTHESIS
   // Previous-cycle copy of the inputs: whenever the last edge was not a reset
   // edge, the register must hold the decode of the nibble seen at that edge.
   logic       chk_valid_reg = 1'b0;
   logic [3:0] chk_num_reg   = 4'h0;

   always_ff @(posedge clk) begin
      chk_valid_reg <= !rst;
      chk_num_reg   <= num;
   end

   a_decode_latency: assert property (@(posedge clk)
      chk_valid_reg |-> (seg_reg == (hex_to_seg(chk_num_reg) ^ POL_MASK)));
`endif

endmodule

// File: rtl/disp_num_hex_decoder.sv
// -----------------------------------------------------------------------------
// disp_num_hex_decoder
// Four-digit multiplexed hex display. Each switch nibble feeds its own
// disp_num; a rotating one-hot-low anode selects which digit drives the
// shared segment bus.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (digits dark, anode back to digit 0)
//   bus  : disp_num_hex_decoder_if.slave (sw in, an and seg out)
// SCAN_CYCLES sets how many clocks each digit stays enabled.
// -----------------------------------------------------------------------------
module disp_num_hex_decoder #(
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter int SCAN_CYCLES    = 50000
) (
   input  logic                   clk,
   input  logic                   rst,
   disp_num_hex_decoder_if.slave  bus
);
   import seg7_pkg::*;

   localparam int               CNT_W     = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);

   logic [CNT_W-1:0] scan_cnt_reg = '0;
   logic [3:0]       an_reg       = 4'b1110;
   logic [6:0]       digit_seg [4];
   logic [6:0]       seg_bus;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digit
         disp_num #(
            .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
         ) u_disp_num (
            .num (bus.sw[4*gi +: 4]),
            .clk (clk),
            .seg (digit_seg[gi]),
            .rst (rst)
         );
      end
   endgenerate

   // Anode rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, one step per scan slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt_reg <= '0;
         an_reg       <= 4'b1110;
      end else if (scan_cnt_reg == SCAN_LAST) begin
         scan_cnt_reg <= '0;
         an_reg       <= {an_reg[2:0], an_reg[3]};
      end else begin
         scan_cnt_reg <= scan_cnt_reg + 1'b1;
      end
   end

   // Disabled digits are forced to zero so the OR passes only the active one.
   // This works for either polarity because a dark inactive contribution is
   // never needed: only one digit is ever unmasked.
   always_comb begin
      seg_bus = '0;
      for (int i = 0; i < 4; i++) begin
         seg_bus = seg_bus | (digit_seg[i] & {7{!an_reg[i]}});
      end
   end

   assign bus.an  = an_reg;
   assign bus.seg = seg_bus;

endmodule

// File: tb/tb_disp_num_hex_decoder.sv
// -----------------------------------------------------------------------------
// tb_disp_num_hex_decoder
// Bench for the single-digit decoder (both polarities) and the four-digit
// scanned display. Expected glyphs come from a list of lit segment letters.
// -----------------------------------------------------------------------------
module tb_disp_num_hex_decoder;

   localparam int SCAN = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       top_rst;
   logic [3:0] num;
   logic [6:0] seg_low;
   logic [6:0] seg_high;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   disp_num_hex_decoder_if bus_if ();

   disp_num_hex_decoder #(
      .SEG_ACTIVE_LOW (1'b1),
      .SCAN_CYCLES    (SCAN)
   ) dut (
      .clk (clk),
      .rst (top_rst),
      .bus (bus_if)
   );

   disp_num #(.SEG_ACTIVE_LOW(1'b1)) u_low (
      .num (num),
      .clk (clk),
      .seg (seg_low),
      .rst (rst)
   );

   disp_num #(.SEG_ACTIVE_LOW(1'b0)) u_high (
      .num (num),
      .clk (clk),
      .seg (seg_high),
      .rst (rst)
   );

   // Lit segments of each glyph, by letter.
   string glyph_lit [16];

   // Spec table of active-low patterns, used by the directed vectors.
   logic [6:0] spec_hex [16];

   typedef struct {
      logic       rst;
      logic [3:0] num;
      logic [6:0] exp_low;
      string      name;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [6:0] model_low(input logic [3:0] v);
      logic [6:0] p;
      logic [2:0] bit_idx;
      string      s;
      p = 7'h7F;
      s = glyph_lit[v];
      for (int k = 0; k < s.len(); k++) begin
         bit_idx = 3'(s.getc(k) - 8'd97);
         p[bit_idx] = 1'b0;
      end
      return p;
   endfunction

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic r, input logic [3:0] n, input logic [6:0] e, input string nm);
      vec_t v;
      v.rst = r; v.num = n; v.exp_low = e; v.name = nm;
      vecs.push_back(v);
   endtask

   initial begin
      logic       r;
      logic [3:0] n;
      logic [6:0] exp;
      logic [1:0] d;
      logic [3:0] one_hot;
      logic [3:0] nib;

      glyph_lit = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                    "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
      spec_hex  = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

      rst       = 1'b1;
      top_rst   = 1'b1;
      num       = 4'h8;
      bus_if.sw = 16'h0000;

      // Power-up value, before any clock edge.
      #1;
      check("powerup_low",  seg_low,    7'h7F);
      check("powerup_high", seg_high,   7'h00);
      check("powerup_bus",  bus_if.seg, 7'h7F);

      // Directed vectors: reset hold, release, sweep, mid-stream reset, toggling.
      for (int i = 0; i < 3; i++) add_vec(1'b1, 4'h8, 7'h7F, $sformatf("rst_hold_%0d", i));
      add_vec(1'b0, 4'h8, 7'h00, "rst_release");
      for (int i = 0; i < 16; i++) add_vec(1'b0, 4'(i), spec_hex[i], $sformatf("sweep_%h", i));
      add_vec(1'b0, 4'h3, 7'h30, "mid_3");
      add_vec(1'b0, 4'h4, 7'h19, "mid_4");
      add_vec(1'b1, 4'h5, 7'h7F, "mid_rst_5");
      add_vec(1'b0, 4'h5, 7'h12, "mid_after_5");
      add_vec(1'b0, 4'h6, 7'h02, "mid_after_6");
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) add_vec(1'b0, 4'h1, 7'h79, $sformatf("toggle_%0d", i));
         else            add_vec(1'b0, 4'hE, 7'h06, $sformatf("toggle_%0d", i));
      end

      @(negedge clk);
      foreach (vecs[i]) begin
         rst = vecs[i].rst;
         num = vecs[i].num;
         @(negedge clk);
         check(vecs[i].name, seg_low, vecs[i].exp_low);
         check({vecs[i].name, "_pol0"}, seg_high, ~vecs[i].exp_low);
         $display("vec %s rst=%0b num=%h seg=%h seg_pol0=%h", vecs[i].name, vecs[i].rst,
                  vecs[i].num, seg_low, seg_high);
      end

      // Random inputs against the glyph model, one cycle of latency.
      for (int i = 0; i < 200; i++) begin
         r   = ($urandom_range(0, 7) == 0);
         n   = 4'($urandom_range(0, 15));
         rst = r;
         num = n;
         exp = r ? 7'h7F : model_low(n);
         @(negedge clk);
         check($sformatf("rand_%0d", i), seg_low, exp);
         check($sformatf("rand_%0d_pol0", i), seg_high, ~exp);
         $display("rand %0d rst=%0b num=%h seg=%h", i, r, n, seg_low);
      end
      rst = 1'b0;

      // Four-digit scanned display.
      bus_if.sw = 16'h12AF;
      top_rst   = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("top_rst_seg", bus_if.seg, 7'h7F);
      check("top_rst_an", {3'b000, bus_if.an}, 7'b000_1110);
      top_rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         d       = 2'((k / SCAN) % 4);
         one_hot = 4'b0001 << d;
         nib     = bus_if.sw[4*d +: 4];
         exp     = model_low(nib);
         check($sformatf("scan_an_%0d", k), {3'b000, bus_if.an}, {3'b000, ~one_hot});
         check($sformatf("scan_seg_%0d", k), bus_if.seg, exp);
         $display("scan %0d an=%b seg=%h", k, bus_if.an, bus_if.seg);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/disp_num_hex_decoder.md
# disp_num_hex_decoder

Module `disp_num` is a registered 4-bit hexadecimal to 7-segment decoder. It converts one nibble into the segment pattern for glyphs 0–9 and A, b, C, d, E, F. The top level uses one instance per display digit, four in total, each fed from one switch nibble. The top level ORs the four outputs into a shared segment bus, using the anode one-hot to mask out all but the active digit.

## Interface
Parameters:
- `SEG_ACTIVE_LOW`, default 1: when 1, a lit segment is driven 0 (common-anode board). When 0, all output bits are inverted.

Ports:
- `clk` input 1: the single clock; every flop is on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `num` input 4: hex value to display, 0x0–0xF.
- `seg` output 7: segment drive. `seg[0]`=a, `seg[1]`=b, `seg[2]`=c, `seg[3]`=d, `seg[4]`=e, `seg[5]`=f, `seg[6]`=g.

Port declaration order is fixed as `num`, `clk`, `seg`, `rst`, because existing instances connect the first three ports by position. `rst` is the last port so that positional 3-port instances remain legal; an unconnected `rst` must still elaborate.

## Operation
- Combinational decode of `num` feeds a 7-bit output register; `seg` is driven directly from that register.
- Active-low patterns (`SEG_ACTIVE_LOW`=1), written as gfedcba in hex:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- With `SEG_ACTIVE_LOW`=0, `seg` is the bitwise inverse of the table above.
- All 16 codes are defined, so there is no default/illegal case. If `num` contains X, the decode must not latch X into reserved state; a plain case statement over the table is sufficient.
- Decode is stateless apart from the output register. Nothing depends on previous values of `num`.

## Timing
- Reset: on a rising `clk` edge with `rst`=1, `seg` becomes all-segments-off. That is 7'h7F when `SEG_ACTIVE_LOW`=1 and 7'h00 when it is 0.
- Reset has priority over decode in the same cycle.
- Latency: `seg` reflects the `num` sampled at rising edge N, valid after edge N. Latency is exactly one cycle.
- `num` changing every cycle must produce a new pattern every cycle, with no holdover.
- Releasing `rst` mid-stream: the first edge with `rst`=0 loads the decode of the `num` present at that edge.
- Power-up with no reset applied: the register initialises to all-off, for FPGA flows.
- There is no handshake; the output is always valid one cycle after the input.

## Structure
- Shared package `seg7_pkg`:
  - `SEG_OFF` constant.
  - The 16 glyph constants `SEG_HEX_0` … `SEG_HEX_F`, in active-low form.
  - Function `hex_to_seg(logic [3:0]) → logic [6:0]`.
- The digit-scan top level and any future multiplexer reuse the package.
- No sub-module. `disp_num` contains the function call, the polarity XOR with {7{!SEG_ACTIVE_LOW}}, and one synchronous-reset register.
- Optional assertions in the RTL:
  - onehot0 check on the decoded-lit segments is not applicable.
  - Instead, assert that `seg` equals `hex_to_seg` of `num` delayed by one cycle whenever reset was low in the previous cycle.

## Test plan
- Reset: hold `rst`=1 with `num`=4'h8 for 3 cycles → `seg`=7'h7F each cycle. Deassert `rst` → one edge later `seg`=7'h00.
- Exhaustive sweep: `num` stepped 0x0→0xF, one value per cycle → `seg` follows the table one cycle behind. Spot checks: 0x0→7'h40, 0x7→7'h78, 0xA→7'h08, 0xF→7'h0E.
- Back-to-back toggling: `num` alternates 0x1/0xE each cycle → `seg` alternates 7'h79/7'h06 with one-cycle lag and no stale cycles.
- Reset mid-stream: while sweeping, assert `rst` for 1 cycle at `num`=0x5 → that cycle's output is 7'h7F. The next edge gives the decode of the current `num`.
- Polarity: instance with `SEG_ACTIVE_LOW`=0, `num`=0x1 → `seg`=7'h06. Under reset → `seg`=7'h00.
- Four-instance system check: four instances on nibbles of 16'h12AF, outputs masked by the rotating one-hot-low anode and ORed. For each anode state, the bus equals 7'h79, 7'h24, 7'h08 or 7'h0E respectively.
